// File: rtl/mul_operand_fifo_param_if.sv
// Operand FIFO bus: push/pop requests in, parallel head taps and status out.
// Error-flag signals exist only when MUL_FIFO_ERR_FLAGS_EN is defined.
interface mul_operand_fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAPS  = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wr_en;
  logic [WIDTH-1:0]      a_in;
  logic [WIDTH-1:0]      b_in;
  logic                  rd_en;
  logic [TAPS*WIDTH-1:0] stage_a;
  logic [TAPS*WIDTH-1:0] stage_b;
  logic [TAPS-1:0]       tap_valid;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
`ifdef MUL_FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  modport master (
    output wr_en, a_in, b_in, rd_en,
`ifdef MUL_FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  stage_a, stage_b, tap_valid, full, empty, count
  );

  modport slave (
    input  wr_en, a_in, b_in, rd_en,
`ifdef MUL_FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output stage_a, stage_b, tap_valid, full, empty, count
  );
endinterface

// File: rtl/mul_operand_fifo_param.sv
// Circular a/b operand FIFO exposing its TAPS head entries in parallel; taps update one edge after push/pop.
// Dropped pushes (full) and ignored pops (empty) are silent; MUL_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
module mul_operand_fifo_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int TAPS  = 3
) (
  input logic clk,
  input logic clear,
  mul_operand_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_acc, push_acc;

  logic [TAPS*WIDTH-1:0] stage_a_c, stage_b_c;
  logic [TAPS-1:0]       tap_valid_c;

  // A full FIFO still takes a push when the head retires in the same cycle.
  assign pop_acc  = bus.rd_en && (count_q != '0);
  assign push_acc = bus.wr_en && ((count_q != CW'(DEPTH)) || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_acc && !pop_acc)      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; stale entries stay hidden behind tap_valid.
  always_ff @(posedge clk) begin
    if (push_acc && !clear) begin
      mem_a_q[wr_ptr_q] <= bus.a_in;
      mem_b_q[wr_ptr_q] <= bus.b_in;
    end
  end

  always_comb begin
    stage_a_c   = '0;
    stage_b_c   = '0;
    tap_valid_c = '0;
    for (int k = 0; k < TAPS; k++) begin
      tap_valid_c[k] = (count_q > CW'(k));
      if (tap_valid_c[k]) begin
        stage_a_c[k*WIDTH +: WIDTH] = mem_a_q[rd_ptr_q + AW'(k)];
        stage_b_c[k*WIDTH +: WIDTH] = mem_b_q[rd_ptr_q + AW'(k)];
      end
    end
  end

  assign bus.stage_a   = stage_a_c;
  assign bus.stage_b   = stage_b_c;
  assign bus.tap_valid = tap_valid_c;
  assign bus.full      = (count_q == CW'(DEPTH));
  assign bus.empty     = (count_q == '0);
  assign bus.count     = count_q;

`ifdef MUL_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && !push_acc)          overflow_q  <= 1'b1;
      if (bus.rd_en && (count_q == '0))    underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: doc/mul_operand_fifo_param.md
MUL_OPERAND_FIFO_PARAM -- requirements
Module: mul_operand_fifo_param

Interface
REQ-001 Parameter WIDTH, 32, operand width in bits; each entry holds one a/b operand pair.
REQ-002 Parameter DEPTH, 8, number of entries; power of two, minimum 4.
REQ-003 Parameter TAPS, 3, number of head entries presented in parallel to the multiplier stages; 1 <= TAPS <= DEPTH.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 clear  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  push request for the a_in/b_in pair.
REQ-007 a_in  input  WIDTH  operand a to push.
REQ-008 b_in  input  WIDTH  operand b to push.
REQ-009 rd_en  input  1  pop request; retires the head entry (tap 0).
REQ-010 stage_a  output  TAPS*WIDTH  flattened taps; bits [k*WIDTH +: WIDTH] hold operand a of the entry k places behind the head.
REQ-011 stage_b  output  TAPS*WIDTH  same layout as stage_a, for operand b.
REQ-012 tap_valid  output  TAPS  bit k is 1 when count > k.
REQ-013 full  output  1  1 when count == DEPTH.
REQ-014 empty  output  1  1 when count == 0.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags; present only per REQ-033.

Function
REQ-017 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 Push SHALL be accepted when wr_en=1 and (full=0 or a pop is accepted in the same cycle); the pair is written at wr_ptr and wr_ptr increments.
REQ-019 Pop SHALL be accepted when rd_en=1 and empty=0; rd_ptr increments.
REQ-020 Push while full without a same-cycle pop SHALL be dropped; storage, pointers and count unchanged.
REQ-021 Pop while empty SHALL be ignored, including when a push is accepted in the same cycle; the pushed entry remains.
REQ-022 count SHALL update by +1 (push only), -1 (pop only), or 0 (both or neither) in the same edge.
REQ-023 Tap k SHALL show the entry at (rd_ptr+k) mod DEPTH, read combinationally from registered storage and pointers; a pushed entry appears on its tap one cycle after the accepting edge.
REQ-024 Tap k with tap_valid[k]=0 SHALL drive all zeros.
REQ-025 After a pop, every tap SHALL shift by one entry at the same edge (old tap k+1 becomes tap k).
REQ-026 full, empty and tap_valid SHALL be decoded from the registered count, without combinational paths from wr_en/rd_en.

Reset
REQ-027 clear=1 SHALL immediately and asynchronously set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, tap_valid=0, and stage_a/stage_b to all zeros.
REQ-028 Storage contents need not be cleared; they SHALL never be visible because tap_valid=0.
REQ-029 clear asserted mid-operation SHALL discard all entries; pushes and pops presented while clear=1 SHALL be ignored.
REQ-030 The first push SHALL be accepted on the first rising edge after clear deasserts.

Configuration
REQ-031 Macro MUL_FIFO_ERR_FLAGS_EN SHALL control the overflow/underflow outputs.
REQ-032 Without the macro, the ports SHALL be absent and dropped or ignored requests SHALL leave no trace.
REQ-033 With the macro, overflow SHALL be set by a dropped push (REQ-020) and underflow by an ignored pop (REQ-021); both SHALL stay set until clear, and both SHALL reset to 0.

Verification (WIDTH=32, DEPTH=8, TAPS=3)
REQ-034 Reset: hold clear=1 for 2 cycles, then release -> count=0, empty=1, full=0, tap_valid=3'b000, stage_a=0.
REQ-035 Fill: push a=b=1..3 on consecutive edges -> one cycle after the third push, stage_a taps 0/1/2 = 1/2/3, tap_valid=3'b111, count=3.
REQ-036 Full and wrap: push 1..8, pop 1, push 9 -> full=1; taps 0/1/2 = 2/3/4; push 10 while full with rd_en=0 -> dropped, count=8, overflow=1 when the macro is defined.
REQ-037 Simultaneous: at count=8, wr_en=rd_en=1 with a_in=10 -> count stays 8, tap 0 advances to 3, and 10 is the tail entry.
REQ-038 Empty corner: at count=0, wr_en=rd_en=1 with a_in=5 -> count=1, tap 0 shows 5, underflow=1 when the macro is defined.
REQ-039 Mid-run reset: at count=5, pulse clear asynchronously between edges -> outputs clear without waiting for an edge; the next push of 7 appears at tap 0 with count=1.
